// File: rtl/gmii_pkt_capture.sv
// GMII transmit-side frame capture into a commit-on-EOP packet buffer with {code,data} output stream.
// Optional macro GMII_CAPTURE_CRC_EN adds an 802.3 CRC-32 residue check that marks failing frames as bad EOP.
module gmii_pkt_capture #(
  parameter int DEPTH = 2048,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gmii_tx_en,
  input  logic             gmii_tx_er,
  input  logic [7:0]       gmii_txd,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [7:0]       p_data,
  output logic [1:0]       p_code,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] SFD    = 8'hD5;
  localparam logic [1:0] C_SOP  = 2'b01;
  localparam logic [1:0] C_MOP  = 2'b00;
  localparam logic [1:0] C_EOPG = 2'b10;
  localparam logic [1:0] C_EOPB = 2'b11;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   wptr, cptr, rptr, wptr_nxt, cptr_nxt;
  logic            stg_vld_p1, stg_sop_p1, stg_vld_nxt;
  logic [7:0]      stg_data_p1;
  logic            err_q, first_q, silent_q, silent_nxt;
  logic            wr_en, capture, full, frame_bad, crc_bad;
  logic            inc_pkt, inc_err, inc_drop;
  logic [9:0]      wr_word, rd_word;
  logic [9:0]      mem [DEPTH];

`ifdef GMII_CAPTURE_CRC_EN
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  logic [31:0] crc_q;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (state != DATA) crc_q <= 32'hFFFFFFFF;
    else if (capture)  crc_q <= crc32_byte(crc_q, gmii_txd);
  end

  // LSB-first register holds the residue bit-reversed relative to the 802.3 constant
  assign crc_bad = (bitrev32(crc_q) != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  assign full      = ((wptr + 1'b1) == rptr);
  assign frame_bad = err_q | crc_bad;

  always_comb begin
    state_nxt   = state;
    wptr_nxt    = wptr;
    cptr_nxt    = cptr;
    stg_vld_nxt = stg_vld_p1;
    silent_nxt  = silent_q;
    wr_en       = 1'b0;
    wr_word     = {C_MOP, stg_data_p1};
    capture     = 1'b0;
    inc_pkt     = 1'b0;
    inc_err     = 1'b0;
    inc_drop    = 1'b0;
    case (state)
      IDLE: begin
        stg_vld_nxt = 1'b0;
        if (gmii_tx_en) begin
          if (first_q) begin
            state_nxt  = DROP;
            silent_nxt = 1'b1;
          end else if (gmii_txd == SFD) begin
            state_nxt = DATA;
          end else begin
            state_nxt = PRE;
          end
        end
      end
      PRE: begin
        if (!gmii_tx_en) begin
          state_nxt = IDLE;
          inc_drop  = 1'b1;
        end else if (gmii_txd == SFD) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (gmii_tx_en) begin
          capture     = 1'b1;
          stg_vld_nxt = 1'b1;
          if (stg_vld_p1) begin
            wr_word = {(stg_sop_p1 ? C_SOP : C_MOP), stg_data_p1};
            if (full) begin
              wptr_nxt    = cptr;
              stg_vld_nxt = 1'b0;
              capture     = 1'b0;
              state_nxt   = DROP;
            end else begin
              wr_en    = 1'b1;
              wptr_nxt = wptr + 1'b1;
            end
          end
        end else begin
          state_nxt   = IDLE;
          stg_vld_nxt = 1'b0;
          // a staged byte that is not the SOP means at least two bytes were captured
          if (stg_vld_p1 && !stg_sop_p1) begin
            wr_word = {(frame_bad ? C_EOPB : C_EOPG), stg_data_p1};
            if (full) begin
              wptr_nxt  = cptr;
              state_nxt = DROP;
            end else begin
              wr_en    = 1'b1;
              wptr_nxt = wptr + 1'b1;
              cptr_nxt = wptr + 1'b1;
              inc_pkt  = 1'b1;
              inc_err  = frame_bad;
            end
          end else begin
            wptr_nxt = cptr;
            inc_drop = 1'b1;
          end
        end
      end
      DROP: begin
        if (!gmii_tx_en) begin
          state_nxt  = IDLE;
          inc_drop   = !silent_q;
          silent_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // stage p1: control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wptr       <= '0;
      cptr       <= '0;
      rptr       <= '0;
      stg_vld_p1 <= 1'b0;
      stg_sop_p1 <= 1'b0;
      err_q      <= 1'b0;
      first_q    <= 1'b1;
      silent_q   <= 1'b0;
      pkt_cnt    <= '0;
      err_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      wptr       <= wptr_nxt;
      cptr       <= cptr_nxt;
      stg_vld_p1 <= stg_vld_nxt;
      if (capture) stg_sop_p1 <= !stg_vld_p1;
      err_q      <= ((state == IDLE) ? 1'b0 : err_q) | (gmii_tx_en & gmii_tx_er);
      first_q    <= 1'b0;
      silent_q   <= silent_nxt;
      if (p_srdy && p_drdy) rptr <= rptr + 1'b1;
      if (inc_pkt)  pkt_cnt  <= pkt_cnt + 1'b1;
      if (inc_err)  err_cnt  <= err_cnt + 1'b1;
      if (inc_drop) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) stg_data_p1 <= gmii_txd;
    if (wr_en)   mem[wptr]   <= wr_word;
  end

  // read side: combinational at rptr, zeroed while nothing is committed
  assign rd_word = mem[rptr];
  assign p_srdy  = (rptr != cptr);
  assign p_data  = p_srdy ? rd_word[7:0] : 8'h00;
  assign p_code  = p_srdy ? rd_word[9:8] : 2'b00;

endmodule
